regfile_wb_arbiter: RTL and testbench

//  Write-side front end for the register file: merges pipeline writeback and late multiply/divide
//  (MDU) results into the single regfile write port (wena/waddr/wdata).

---
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges pipeline writeback and queued MDU results onto the single regfile write port
module regfile_wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pipe_wena,
   input  logic [AW-1:0]              pipe_waddr,
   input  logic [DW-1:0]              pipe_wdata,
   input  logic                       mdu_valid,
   input  logic [AW-1:0]              mdu_waddr,
   input  logic [DW-1:0]              mdu_wdata,
   output logic                       mdu_ready,
   input  logic [AW-1:0]              raddr1,
   input  logic [AW-1:0]              raddr2,
   output logic                       pend1,
   output logic                       pend2,
   output logic                       wena,
   output logic [AW-1:0]              waddr,
   output logic [DW-1:0]              wdata,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0]    ent_addr_q [DEPTH];
   logic [AW-1:0]    ent_addr_d [DEPTH];
   logic [DW-1:0]    ent_data_q [DEPTH];
   logic [DW-1:0]    ent_data_d [DEPTH];
   logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             wena_q, wena_d;
   logic [AW-1:0]    waddr_q, waddr_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic             pipe_hit, mdu_acc, fifo_empty, pop, push;

   assign mdu_ready  = cnt_q != CW'(DEPTH);
   assign fifo_count = cnt_q;
   assign wena       = wena_q;
   assign waddr      = waddr_q;
   assign wdata      = wdata_q;

   // arbitration: pipe hit, else FIFO head (a squashed head pops as a silent bubble), else MDU bypass
   always_comb begin
      pipe_hit   = pipe_wena && pipe_waddr != '0;
      mdu_acc    = mdu_valid && mdu_ready && mdu_waddr != '0;
      fifo_empty = cnt_q == '0;
      pop        = !pipe_hit && !fifo_empty;
      push       = pipe_hit ? (mdu_acc && mdu_waddr != pipe_waddr) : (mdu_acc && !fifo_empty);
      wena_d     = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      if (pipe_hit) begin
         wena_d  = 1'b1;
         waddr_d = pipe_waddr;
         wdata_d = pipe_wdata;
      end else if (pop && ent_vld_q[rd_ptr_q]) begin
         wena_d  = 1'b1;
         waddr_d = ent_addr_q[rd_ptr_q];
         wdata_d = ent_data_q[rd_ptr_q];
      end else if (fifo_empty && mdu_acc) begin
         wena_d  = 1'b1;
         waddr_d = mdu_waddr;
         wdata_d = mdu_wdata;
      end
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
   end

   // FIFO slot update: a younger pipe write squashes matching entries, pop frees the head, push fills the tail
   always_comb begin
      ent_vld_d  = ent_vld_q;
      ent_addr_d = ent_addr_q;
      ent_data_d = ent_data_q;
      for (int i = 0; i < DEPTH; i++)
         if (pipe_hit && ent_addr_q[i] == pipe_waddr) ent_vld_d[i] = 1'b0;
      if (pop) ent_vld_d[rd_ptr_q] = 1'b0;
      if (push) begin
         ent_vld_d[wr_ptr_q]  = 1'b1;
         ent_addr_d[wr_ptr_q] = mdu_waddr;
         ent_data_d[wr_ptr_q] = mdu_wdata;
      end
   end

   // hazard query: a read address is pending while any live queued entry targets it
   always_comb begin
      pend1 = 1'b0;
      pend2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         pend1 = pend1 | (ent_vld_q[i] && ent_addr_q[i] == raddr1);
         pend2 = pend2 | (ent_vld_q[i] && ent_addr_q[i] == raddr2);
      end
      pend1 = pend1 && raddr1 != '0;
      pend2 = pend2 && raddr2 != '0;
   end

   // control state and registered write port
   always_ff @(posedge clk) begin
      if (rst) begin
         ent_vld_q <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
         wena_q    <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         ent_vld_q <= ent_vld_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         wena_q    <= wena_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
      end
   end

   // FIFO payload storage, qualified by the valid bits
   always_ff @(posedge clk) begin
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: vector table plus hand sequences, all regfile writes checked through an in-order scoreboard
module tb_regfile_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pipe_wena = 1'b0;
   logic [4:0]  pipe_waddr = '0;
   logic [31:0] pipe_wdata = '0;
   logic        mdu_valid = 1'b0;
   logic [4:0]  mdu_waddr = '0;
   logic [31:0] mdu_wdata = '0;
   logic        mdu_ready;
   logic [4:0]  raddr1 = '0;
   logic [4:0]  raddr2 = '0;
   logic        pend1, pend2, wena;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [2:0]  fifo_count;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;
   wr_t exp_q[$];

   typedef struct {
      logic pw; logic [4:0] pa; logic [31:0] pd;
      logic mv; logic [4:0] ma; logic [31:0] md;
      logic ew; logic [4:0] ea; logic [31:0] ed;
      logic [2:0] ec; logic ep;
      logic qv; logic [4:0] qa; logic [31:0] qd;
   } vec_t;
   vec_t tbl[8];

   regfile_wb_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .pipe_wena(pipe_wena), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
      .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata), .mdu_ready(mdu_ready),
      .raddr1(raddr1), .raddr2(raddr2), .pend1(pend1), .pend2(pend2),
      .wena(wena), .waddr(waddr), .wdata(wdata), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                      input logic mv, input logic [4:0] ma, input logic [31:0] md);
      @(negedge clk);
      pipe_wena = pw; pipe_waddr = pa; pipe_wdata = pd;
      mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: every regfile write must match the next expected write in order
   initial begin
      wr_t e;
      forever begin
         @(posedge clk);
         #1;
         if (wena === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_unexpected: got write r%0d=0x%0h expected no write", waddr, wdata);
            end else begin
               e = exp_q.pop_front();
               chk("sb_waddr", waddr, e.a);
               chk("sb_wdata", wdata, e.d);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int idx;
      //          pw pa  pd      mv ma  md      ew ea  ed     ec ep  qv qa  qd
      tbl[0] = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  32'h11, 1'b1, 5'd5,  32'h11, 3'd0, 1'b0, 1'b0, 5'd0, 32'h0};
      tbl[1] = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd5,  32'h11, 3'd0, 1'b0, 1'b0, 5'd0, 32'h0};
      tbl[2] = '{1'b1, 5'd3,  32'hA,  1'b1, 5'd7,  32'hB,  1'b1, 5'd3,  32'hA,  3'd1, 1'b1, 1'b1, 5'd7, 32'hB};
      tbl[3] = '{1'b1, 5'd0,  32'h55, 1'b1, 5'd0,  32'h66, 1'b0, 5'd7,  32'hB,  3'd0, 1'b0, 1'b0, 5'd0, 32'h0};
      tbl[4] = '{1'b1, 5'd6,  32'h1,  1'b1, 5'd6,  32'h2,  1'b1, 5'd6,  32'h1,  3'd0, 1'b0, 1'b0, 5'd0, 32'h0};
      tbl[5] = '{1'b1, 5'd0,  32'h9,  1'b1, 5'd10, 32'h77, 1'b1, 5'd10, 32'h77, 3'd0, 1'b0, 1'b0, 5'd0, 32'h0};
      tbl[6] = '{1'b1, 5'd12, 32'h5,  1'b0, 5'd12, 32'h8,  1'b1, 5'd12, 32'h5,  3'd0, 1'b0, 1'b0, 5'd0, 32'h0};
      tbl[7] = '{1'b0, 5'd13, 32'h6,  1'b0, 5'd14, 32'h7,  1'b0, 5'd12, 32'h5,  3'd0, 1'b0, 1'b0, 5'd0, 32'h0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_wena", wena, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ready", mdu_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      // reset discards three queued MDU results
      raddr1 = 5'd2;
      raddr2 = 5'd3;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back('{5'(20 + k), 32'h300 + k});
         drv(1'b1, 5'(20 + k), 32'h300 + k, 1'b1, 5'(1 + k), 32'h400 + k);
         step();
      end
      chk("t1_count", fifo_count, 3);
      chk("t1_pend1", pend1, 1);
      chk("t1_pend2", pend2, 1);
      drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      rst = 1'b1;
      step();
      chk("t1_wena", wena, 0);
      chk("t1_waddr", waddr, 0);
      chk("t1_count0", fifo_count, 0);
      chk("t1_pend1_0", pend1, 0);
      chk("t1_pend2_0", pend2, 0);
      chk("t1_ready", mdu_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      // single-cycle vectors from an empty FIFO, each followed by two idle cycles
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].ew) exp_q.push_back('{tbl[i].ea, tbl[i].ed});
         if (tbl[i].qv) exp_q.push_back('{tbl[i].qa, tbl[i].qd});
         drv(tbl[i].pw, tbl[i].pa, tbl[i].pd, tbl[i].mv, tbl[i].ma, tbl[i].md);
         raddr1 = tbl[i].ma;
         raddr2 = 5'd0;
         step();
         chk($sformatf("v%0d_wena", i), wena, tbl[i].ew);
         chk($sformatf("v%0d_waddr", i), waddr, tbl[i].ea);
         chk($sformatf("v%0d_wdata", i), wdata, tbl[i].ed);
         chk($sformatf("v%0d_count", i), fifo_count, tbl[i].ec);
         chk($sformatf("v%0d_pend1", i), pend1, tbl[i].ep);
         chk($sformatf("v%0d_pend2", i), pend2, 0);
         drv(1'b0, tbl[i].pa, 32'h0, 1'b0, tbl[i].ma, 32'h0);
         repeat (2) @(posedge clk);
      end

      // pipe holds the port for five cycles while the MDU fills the FIFO, then in-order drain
      for (int k = 0; k < 5; k++) exp_q.push_back('{5'(20 + k), 32'h100 + k});
      for (int k = 0; k < 5; k++) exp_q.push_back('{5'(8 + k), 32'h200 + k});
      raddr1 = 5'd8;
      idx = 0;
      for (int k = 0; k < 11; k++) begin
         drv(k < 5, 5'(20 + k), 32'h100 + k, idx < 5, 5'(8 + idx), 32'h200 + idx);
         #1;
         if (k < 7) chk($sformatf("t4_ready_%0d", k), mdu_ready, k < 4 || k == 6);
         acc = mdu_valid && mdu_ready;
         step();
         if (acc) idx++;
         if (k == 4) begin
            chk("t4_count_full", fifo_count, 4);
            chk("t4_pend_r8", pend1, 1);
         end
         if (k == 5) chk("t4_pend_r8_gone", pend1, 0);
         if (k >= 5) chk($sformatf("t4_wena_%0d", k), wena, k < 10);
      end

      // squashed r9 becomes a bubble, r4 still issues after it
      exp_q.push_back('{5'd20, 32'h50});
      exp_q.push_back('{5'd21, 32'h51});
      exp_q.push_back('{5'd9, 32'h3});
      exp_q.push_back('{5'd4, 32'h2});
      raddr1 = 5'd9;
      raddr2 = 5'd4;
      drv(1'b1, 5'd20, 32'h50, 1'b1, 5'd9, 32'h1);
      step();
      drv(1'b1, 5'd21, 32'h51, 1'b1, 5'd4, 32'h2);
      step();
      drv(1'b1, 5'd9, 32'h3, 1'b0, 5'd0, 32'h0);
      #1;
      chk("t5_pend_r9", pend1, 1);
      chk("t5_pend_r4", pend2, 1);
      step();
      chk("t5_squash_pend", pend1, 0);
      chk("t5_pend_r4_kept", pend2, 1);
      chk("t5_count", fifo_count, 2);
      drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      step();
      chk("t5_bubble_wena", wena, 0);
      chk("t5_bubble_waddr", waddr, 9);
      chk("t5_bubble_wdata", wdata, 3);
      chk("t5_bubble_count", fifo_count, 1);
      step();
      chk("t5_r4_wena", wena, 1);
      chk("t5_r4_waddr", waddr, 4);
      chk("t5_r4_pend", pend2, 0);

      repeat (4) step();
      chk("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
